// File: rtl/sample_pkg.sv
// Shared sample type, gain constants and the effect-control FSM state encoding.
package sample_pkg;

    typedef struct packed {
        logic signed [15:0] lc;
        logic signed [15:0] rc;
    } sample_t;

    localparam int unsigned GAIN_WIDTH = 9;
    localparam logic [GAIN_WIDTH-1:0] GAIN_UNITY = 9'd256;

    typedef enum logic [1:0] {
        IDLE,
        FADE_OUT,
        MUTE,
        FADE_IN
    } eff_state_t;

    // Signed full-width product, arithmetic shift by 8, truncate: gain 256 is exact passthrough.
    function automatic logic signed [15:0] apply_gain(input logic signed [15:0] x,
                                                      input logic [GAIN_WIDTH-1:0] g);
        logic signed [25:0] p;
        p = $signed({{10{x[15]}}, x}) * $signed({17'b0, g});
        return 16'(p >>> 8);
    endfunction

endpackage

// File: rtl/eff_debounce.sv
// Two-flop synchroniser followed by a candidate/stable debouncer for a switch vector.
module eff_debounce #(
    parameter int unsigned WIDTH        = 17,
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);

    localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Counter saturates; candidate has been equal for DEBOUNCE_CYC cycles.
            stable_d = cand_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/eff_ctrl.sv
// Effect-select controller: debounces switches and swaps the applied selection only while
// the output is muted, ramping the sample gain down and back up around each swap.
module eff_ctrl
    import sample_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned HOLD_SAMPLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw_i,
    input  logic        en_i,
    output logic [15:0] sel_o,
    output logic        en_o,
    input  sample_t     data_i,
    input  logic        vld_i,
    output sample_t     data_o,
    output logic        vld_o,
    output logic        busy_o
);

    localparam int unsigned HW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_SAMPLES - 1);
    localparam logic [GAIN_WIDTH-1:0] GAIN_TOP = GAIN_UNITY - 9'd1;

    logic [16:0] stable;

    eff_debounce #(
        .WIDTH        (17),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .raw    ({en_i, sw_i}),
        .stable (stable)
    );

    eff_state_t            state_q, state_d;
    logic [GAIN_WIDTH-1:0] gain_q, gain_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [15:0]           sel_q, sel_d;
    logic                  en_q, en_d;
    sample_t               data_q;
    logic                  vld_q;
    logic                  changed;

    assign changed = (stable != {en_q, sel_q});

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        en_d    = en_q;
        unique case (state_q)
            IDLE: begin
                gain_d = GAIN_UNITY;
                if (changed) state_d = FADE_OUT;
            end
            FADE_OUT: begin
                // A reversal from FADE_IN can arrive here already at zero gain.
                if (gain_q == '0) begin
                    state_d        = MUTE;
                    hold_d         = '0;
                    {en_d, sel_d}  = stable;
                end else if (vld_i) begin
                    gain_d = gain_q - 9'd1;
                    if (gain_q == 9'd1) begin
                        state_d       = MUTE;
                        hold_d        = '0;
                        {en_d, sel_d} = stable;
                    end
                end
            end
            MUTE: begin
                gain_d = '0;
                if (vld_i) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (changed) {en_d, sel_d} = stable;
                        else         state_d = FADE_IN;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            FADE_IN: begin
                if (changed) begin
                    state_d = FADE_OUT;
                    if (vld_i && gain_q != '0) gain_d = gain_q - 9'd1;
                end else if (vld_i) begin
                    gain_d = gain_q + 9'd1;
                    if (gain_q == GAIN_TOP) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gain_q  <= GAIN_UNITY;
            hold_q  <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
        end
    end

    // Each sample is scaled by the gain in force before that sample's step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= vld_i;
            if (vld_i) begin
                data_q.lc <= apply_gain(data_i.lc, gain_q);
                data_q.rc <= apply_gain(data_i.rc, gain_q);
            end
        end
    end

    assign sel_o  = sel_q;
    assign en_o   = en_q;
    assign data_o = data_q;
    assign vld_o  = vld_q;
    assign busy_o = (state_q != IDLE);

endmodule
